// File: rtl/adpll_pkg.sv
// Shared types and helpers for the ADPLL loop controller.
package adpll_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACQUIRE  = 2'd1,
        TRACK    = 2'd2,
        HOLDOVER = 2'd3
    } state_t;

    typedef struct packed {
        logic [5:0] kp;
        logic [5:0] ki;
    } gear_t;

    // Clamp a wide signed value to the range of a w-bit signed word.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                      input int unsigned       w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/adpll_hist_avg.sv
// Circular history of integrator samples with a running sum; avg is sum / DEPTH
// (unwritten entries count as zero until the buffer has wrapped once).
module adpll_hist_avg #(
    parameter int unsigned W     = 27,
    parameter int unsigned DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                wr,
    input  logic signed [W-1:0] din,
    output logic signed [W-1:0] avg
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned SW = W + AW;

    logic signed [W-1:0]  mem [DEPTH];
    logic        [AW-1:0] ptr;
    logic signed [SW-1:0] sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            ptr <= '0;
            sum <= '0;
        end else if (clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            ptr <= '0;
            sum <= '0;
        end else if (wr) begin
            mem[ptr] <= din;
            ptr      <= ptr + AW'(1);
            sum      <= sum - SW'(mem[ptr]) + SW'(din);
        end
    end

    assign avg = W'(sum >>> AW);

endmodule

// File: rtl/adpll_loop_ctrl.sv
// ADPLL loop controller: gear-shifted PI filter, lock detection, saturation with
// anti-windup and holdover from an averaged integrator history.
module adpll_loop_ctrl
    import adpll_pkg::*;
#(
    parameter int unsigned TDC_W      = 7,
    parameter int unsigned DCO_W      = 27,
    parameter int unsigned FRAC_W     = 8,
    parameter int unsigned KP_ACQ     = 2,
    parameter int unsigned KI_ACQ     = 6,
    parameter int unsigned KP_TRK     = 4,
    parameter int unsigned KI_TRK     = 10,
    parameter int unsigned LOCK_THR   = 2,
    parameter int unsigned LOCK_CNT   = 64,
    parameter int unsigned UNLOCK_CNT = 4,
    parameter int unsigned HOLD_TO    = 16,
    parameter int unsigned HIST_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic signed [TDC_W-1:0] tdc_err,
    input  logic                    tdc_valid,
    input  logic signed [DCO_W-1:0] dco_center,
    output logic signed [DCO_W-1:0] dco_word,
    output logic                    dco_upd,
    output logic                    locked,
    output logic                    holdover
);

    localparam int unsigned IW  = DCO_W + FRAC_W;
    localparam int unsigned ICW = $clog2(LOCK_CNT + 1);
    localparam int unsigned OCW = $clog2(UNLOCK_CNT + 1);
    localparam int unsigned TCW = $clog2(HOLD_TO + 1);

    state_t                  state, state_nxt;
    gear_t                   gear;
    logic signed [IW-1:0]    integ, integ_nxt;
    logic signed [DCO_W-1:0] dco_nxt, hold_nxt, avg;
    logic signed [63:0]      e_raw, e_abs, e_fx, prop;
    logic                    in_lock, proc, hist_wr, hist_clr;
    logic [ICW-1:0]          in_cnt, in_cnt_nxt;
    logic [OCW-1:0]          out_cnt, out_cnt_nxt;
    logic [TCW-1:0]          to_cnt;

    always_comb begin
        gear = (state == TRACK) ? gear_t'{kp: 6'(KP_TRK), ki: 6'(KI_TRK)}
                                : gear_t'{kp: 6'(KP_ACQ), ki: 6'(KI_ACQ)};
        e_raw     = 64'(tdc_err);
        e_abs     = (e_raw < 0) ? -e_raw : e_raw;
        in_lock   = (e_abs <= 64'(LOCK_THR));
        e_fx      = e_raw <<< FRAC_W;
        prop      = e_fx >>> gear.kp;
        integ_nxt = IW'(sat_signed(64'(integ) + (e_fx >>> gear.ki), IW));
        dco_nxt   = DCO_W'(sat_signed(((64'(integ_nxt) + prop) >>> FRAC_W) + 64'(dco_center), DCO_W));
        hold_nxt  = DCO_W'(sat_signed(64'(avg) + 64'(dco_center), DCO_W));
        proc      = tdc_valid && enable && (state == ACQUIRE || state == TRACK);
        hist_wr   = proc && (state == TRACK);
        hist_clr  = !enable;
        in_cnt_nxt  = in_lock ? ((in_cnt == ICW'(LOCK_CNT)) ? in_cnt : in_cnt + ICW'(1)) : '0;
        out_cnt_nxt = in_lock ? '0 : ((out_cnt == OCW'(UNLOCK_CNT)) ? out_cnt : out_cnt + OCW'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:     state_nxt = ACQUIRE;
                ACQUIRE:  if (proc && in_cnt_nxt == ICW'(LOCK_CNT)) state_nxt = TRACK;
                TRACK: begin
                    if (proc && out_cnt_nxt == OCW'(UNLOCK_CNT))          state_nxt = ACQUIRE;
                    else if (!tdc_valid && to_cnt == TCW'(HOLD_TO - 1))   state_nxt = HOLDOVER;
                end
                HOLDOVER: if (tdc_valid) state_nxt = ACQUIRE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        locked   = (state == TRACK) || (state == HOLDOVER);
        holdover = (state == HOLDOVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            to_cnt  <= '0;
        end else begin
            if (!enable || state == IDLE || state == HOLDOVER) begin
                in_cnt  <= '0;
                out_cnt <= '0;
            end else if (proc) begin
                in_cnt  <= in_cnt_nxt;
                out_cnt <= out_cnt_nxt;
            end
            if (enable && state == TRACK && !tdc_valid)
                to_cnt <= (to_cnt == TCW'(HOLD_TO)) ? to_cnt : to_cnt + TCW'(1);
            else
                to_cnt <= '0;
        end
    end

    // Leaving holdover reloads the integrator from the history average so the
    // first tracked sample continues from the held control word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ    <= '0;
            dco_word <= '0;
            dco_upd  <= 1'b0;
        end else begin
            dco_upd <= 1'b0;
            if (!enable) begin
                integ    <= '0;
                dco_word <= dco_center;
                dco_upd  <= (state != IDLE);
            end else if (state == HOLDOVER && tdc_valid) begin
                integ <= {avg, {FRAC_W{1'b0}}};
            end else if (proc) begin
                integ    <= integ_nxt;
                dco_word <= dco_nxt;
                dco_upd  <= 1'b1;
            end else if (state == TRACK && state_nxt == HOLDOVER) begin
                dco_word <= hold_nxt;
                dco_upd  <= 1'b1;
            end
        end
    end

    adpll_hist_avg #(
        .W     (DCO_W),
        .DEPTH (HIST_DEPTH)
    ) u_hist (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (hist_clr),
        .wr    (hist_wr),
        .din   (integ_nxt[IW-1:FRAC_W]),
        .avg   (avg)
    );

endmodule
